axis_pkt_checker: RTL
=====================

AXIS_PKT_CHECKER -- requirements
Module: axis_pkt_checker

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 512, AXIS tdata width; KEEP_WIDTH, default 64, AXIS tkeep width; USER_WIDTH, default 1, AXIS tuser width.
REQ-002 SHALL have ports (name  direction  width  meaning):
 CLK  in  1  single clock, shared with the CMAC RX user-side stream.
 RST_N  in  1  reset, asynchronous assert, active-low.
 cfg_valid  in  1  one-cycle start pulse.
 cfg_pkt_size  in  16  beats per packet.
 cfg_pkt_num  in  32  packets expected.
 s_axis_tvalid  in  1  RX stream valid, from CMAC RX wrapper.
 s_axis_tready  out  1  RX stream ready.
 s_axis_tdata  in  DATA_WIDTH  RX payload.
 s_axis_tkeep  in  KEEP_WIDTH  byte enables.
 s_axis_tlast  in  1  end of packet.
 s_axis_tuser  in  USER_WIDTH  error flag from MAC.
 recv_pkt_count  out  32  packets closed by tlast.
 err_pkt_count  out  32  packets with at least one error.
 total_beat_count  out  32  beats accepted.
 cycle_count  out  32  cycles from first accepted beat to done.
 busy  out  1  high in RUN.
 done  out  1  high in DONE.

Function
REQ-003 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on cfg_valid; RUN->DONE in the cycle after recv_pkt_count reaches cfg_pkt_num; DONE->RUN on cfg_valid.
REQ-004 SHALL latch cfg_pkt_size and cfg_pkt_num on accepted cfg_valid, treating cfg_pkt_size 0 as 1.
REQ-005 SHALL clear all four counters and the per-packet state on accepted cfg_valid.
REQ-006 SHALL ignore cfg_valid while in RUN.
REQ-007 SHALL go RUN->DONE one cycle after accepting cfg_pkt_num 0, without accepting any beat.
REQ-008 SHALL drive s_axis_tready high only in RUN and only while recv_pkt_count < cfg_pkt_num, registered, with no combinational path from tvalid.
REQ-009 SHALL define a beat as accepted when tvalid and tready are both high, and SHALL increment total_beat_count once per accepted beat.
REQ-010 SHALL expect packet n (0-based, n = recv_pkt_count) to carry tdata[31:0] = n and tdata[47:32] = beat index i on every beat, with i starting at 0 and wrapping at 16 bits.
REQ-011 SHALL mark the current packet errored if any accepted beat has:
 - a tdata[31:0] mismatch;
 - a tdata[47:32] mismatch;
 - tkeep not all ones;
 - any tuser bit set;
 - tlast at i != size-1;
 - no tlast at i = size-1.
REQ-012 SHALL, for a packet with no tlast at i = size-1, keep consuming and indexing beats until tlast.
REQ-013 SHALL, on an accepted tlast beat, increment recv_pkt_count by 1, and SHALL also increment err_pkt_count by 1 if the packet is errored (at most once per packet, including errors on the tlast beat itself), then reset i and the error flag.
REQ-014 SHALL start cycle_count on the first accepted beat after cfg (that cycle counts as 1), increment it every cycle in RUN thereafter, freeze it on entry to DONE, and saturate it at 0xFFFFFFFF.
REQ-015 SHALL saturate recv_pkt_count, err_pkt_count and total_beat_count at 0xFFFFFFFF.
REQ-016 SHALL register all outputs, with counters visible the cycle after the triggering beat.

Reset
REQ-017 SHALL, while RST_N is low, force: state IDLE; s_axis_tready 0; busy 0; done 0; all counters 0; i 0; error flag 0; latched cfg 0.
REQ-018 SHALL on reset mid-packet discard the partial packet without counting it, and SHALL require a new cfg_valid after reset.

Verification
REQ-019 Scenario: cfg size=4, num=3; 12 clean beats with tvalid held high -> recv=3, err=0, beats=12, cycle_count=12, done one cycle after the last tlast.
REQ-020 Scenario: size=4, num=2; packet 0 beat 2 has tdata[31:0]=7 -> recv=2, err=1, beats=8.
REQ-021 Scenario: size=4, num=2; packet 0 has tlast at i=1, then packet 1 clean (seq=1) -> recv=2, err=1, beats=6.
REQ-022 Scenario: size=2, num=1; tlast at i=3 -> recv=1, err=1, beats=4.
REQ-023 Scenario: cfg num=0 -> done after 1 cycle, tready never high, all counters 0.
REQ-024 Scenario: RST_N low mid-packet (beat 2 of 4), then cfg size=4, num=1, clean packet -> recv=1, err=0, beats=4.

Source files
------------

// File: rtl/axis_pkt_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pkt_checker_if
//  Purpose  : AXI4-Stream bundle carrying the CMAC RX user-side stream into
//             the packet checker.
//  Revision : 1.0  initial release
// ============================================================================
interface axis_pkt_checker_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_pkt_checker.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pkt_checker
//  Purpose  : Consumes a numbered test-packet stream, checks sequence/index
//             fields and framing, and accumulates packet/beat/cycle counters.
//  Revision : 1.0  initial release
// ============================================================================
module axis_pkt_checker #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,

    input  wire logic         cfg_valid,
    input  wire logic [15:0]  cfg_pkt_size,
    input  wire logic [31:0]  cfg_pkt_num,

    axis_pkt_checker_if.slave s_axis,

    output logic [31:0]       recv_pkt_count,
    output logic [31:0]       err_pkt_count,
    output logic [31:0]       total_beat_count,
    output logic [31:0]       cycle_count,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic [1:0]  r_state;
    logic [15:0] r_cfg_size;
    logic [31:0] r_cfg_num;
    logic [15:0] r_beat_idx;
    logic        r_pkt_err;
    logic        r_started;
    logic        r_tready;

    logic [1:0]  w_state_nxt;
    logic        w_cfg_accept;
    logic        w_beat_acc;
    logic [15:0] w_last_idx;
    logic        w_at_last_idx;
    logic        w_beat_err;
    logic [31:0] w_recv_nxt;
    logic        w_tready_nxt;
    logic [15:0] w_size_eff;

    assign s_axis.tready = r_tready;

    // Upper payload bits carry no checked content.
    generate
        if (DATA_WIDTH > 48) begin : g_tdata_unused
            logic w_unused_tdata;
            assign w_unused_tdata = ^s_axis.tdata[DATA_WIDTH-1:48];
        end
    endgenerate

    assign w_cfg_accept  = cfg_valid && (r_state != c_RUN);
    assign w_beat_acc    = s_axis.tvalid && r_tready;
    assign w_size_eff    = (cfg_pkt_size == 16'd0) ? 16'd1 : cfg_pkt_size;
    assign w_last_idx    = r_cfg_size - 16'd1;
    assign w_at_last_idx = (r_beat_idx == w_last_idx);

    always_comb begin
        w_beat_err = 1'b0;
        if (s_axis.tdata[31:0] != recv_pkt_count)  w_beat_err = 1'b1;
        if (s_axis.tdata[47:32] != r_beat_idx)     w_beat_err = 1'b1;
        if (!(&s_axis.tkeep))                      w_beat_err = 1'b1;
        if (|s_axis.tuser)                         w_beat_err = 1'b1;
        if (s_axis.tlast != w_at_last_idx)         w_beat_err = 1'b1;
    end

    always_comb begin
        w_recv_nxt = recv_pkt_count;
        if (w_beat_acc && s_axis.tlast && (recv_pkt_count != c_CNT_MAX)) begin
            w_recv_nxt = recv_pkt_count + 32'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_cfg_accept) w_state_nxt = c_RUN;
            c_RUN:   if (recv_pkt_count >= r_cfg_num) w_state_nxt = c_DONE;
            c_DONE:  if (w_cfg_accept) w_state_nxt = c_RUN;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Ready drops on the same edge the final tlast is counted, so no extra beat slips in.
    always_comb begin
        w_tready_nxt = 1'b0;
        if (w_cfg_accept) begin
            w_tready_nxt = (cfg_pkt_num != 32'd0);
        end else if (r_state == c_RUN) begin
            w_tready_nxt = (w_recv_nxt < r_cfg_num);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state          <= c_IDLE;
            r_tready         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            r_cfg_size       <= 16'd0;
            r_cfg_num        <= 32'd0;
            r_beat_idx       <= 16'd0;
            r_pkt_err        <= 1'b0;
            r_started        <= 1'b0;
            recv_pkt_count   <= 32'd0;
            err_pkt_count    <= 32'd0;
            total_beat_count <= 32'd0;
            cycle_count      <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= w_tready_nxt;
            busy     <= (w_state_nxt == c_RUN);
            done     <= (w_state_nxt == c_DONE);

            if (w_cfg_accept) begin
                r_cfg_size       <= w_size_eff;
                r_cfg_num        <= cfg_pkt_num;
                r_beat_idx       <= 16'd0;
                r_pkt_err        <= 1'b0;
                r_started        <= 1'b0;
                recv_pkt_count   <= 32'd0;
                err_pkt_count    <= 32'd0;
                total_beat_count <= 32'd0;
                cycle_count      <= 32'd0;
            end else if (r_state == c_RUN) begin
                if (w_beat_acc) begin
                    if (total_beat_count != c_CNT_MAX) begin
                        total_beat_count <= total_beat_count + 32'd1;
                    end
                    if (s_axis.tlast) begin
                        recv_pkt_count <= w_recv_nxt;
                        if ((r_pkt_err || w_beat_err) && (err_pkt_count != c_CNT_MAX)) begin
                            err_pkt_count <= err_pkt_count + 32'd1;
                        end
                        r_beat_idx <= 16'd0;
                        r_pkt_err  <= 1'b0;
                    end else begin
                        r_beat_idx <= r_beat_idx + 16'd1;
                        r_pkt_err  <= r_pkt_err | w_beat_err;
                    end
                end

                // Counting stops on the edge that moves the FSM into DONE.
                if (w_beat_acc && !r_started) begin
                    r_started   <= 1'b1;
                    cycle_count <= 32'd1;
                end else if (r_started && (recv_pkt_count < r_cfg_num) &&
                             (cycle_count != c_CNT_MAX)) begin
                    cycle_count <= cycle_count + 32'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
